psum_accumulator: RTL and testbench

- Downstream of pe_array. Consumes its 112-bit feature_out: 7 lanes of 16-bit signed partial sums.
- Accumulates partial sums across input channels for one row of output tiles in a local buffer.
- After the last channel, applies optional ReLU and 16-bit saturation, then streams the finished row out through a valid/ready handshake.
- One run = cfg_channels passes × cfg_tiles vectors.

---
 rtl/pe_pkg.sv | 18 +
 rtl/psum_sat_relu.sv | 25 ++
 rtl/psum_accumulator.sv | 164 ++++++++++++++++
 tb/tb_psum_accumulator.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types for the pe_array / psum_accumulator datapath.
package pe_pkg;

  localparam int unsigned LANES  = 7;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 26;

  typedef logic signed [DATA_W-1:0] lane_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef lane_t [LANES-1:0]        vec_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } acc_state_t;

endpackage

// File: rtl/psum_sat_relu.sv
// Per-lane output stage: optional ReLU, then saturation of an accumulator to lane width.
module psum_sat_relu
  import pe_pkg::*;
#(
  parameter bit RELU_EN = 1'b1
) (
  input  acc_t  acc,
  output lane_t result_c
);

  localparam acc_t SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam acc_t SAT_MIN = ACC_W'(-(1 << (DATA_W - 1)));

  always_comb begin
    result_c = acc[DATA_W-1:0];
    if (RELU_EN && acc[ACC_W-1]) begin
      result_c = '0;
    end else if (acc > SAT_MAX) begin
      result_c = DATA_W'(SAT_MAX);
    end else if (acc < SAT_MIN) begin
      result_c = DATA_W'(SAT_MIN);
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates pe_array partial sums across input channels for one row of tiles,
// then streams the saturated row out over a valid/ready handshake.
module psum_accumulator
  import pe_pkg::*;
#(
  parameter int unsigned DEPTH   = 32,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [9:0]              cfg_channels,
  input  logic [5:0]              cfg_tiles,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] psum_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam int unsigned CH_W       = 10;
  localparam int unsigned TILE_CFG_W = 6;
  localparam logic [TILE_CFG_W-1:0] TILES_LIM = TILE_CFG_W'(DEPTH);

  acc_state_t       state_q, state_d;
  logic [CH_W-1:0]  ch_m1_q, ch_m1_d;
  logic [CH_W-1:0]  ch_cnt_q, ch_cnt_d;
  logic [IDX_W-1:0] tiles_m1_q, tiles_m1_d;
  logic [IDX_W-1:0] tile_cnt_q, tile_cnt_d;
  logic [IDX_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             in_ready_d, out_valid_d, busy_d, done_d;
  vec_t             out_data_d;
  logic             acc_we_c;
  logic [IDX_W-1:0] rd_idx_c;

  vec_t psum_vec;
  vec_t sat_vec;
  acc_t acc_mem [DEPTH][LANES];
  acc_t rd_acc [LANES];

  assign psum_vec = psum_in;

  // Channel 0 overwrites the entry, so stale sums from earlier runs never leak in.
  always_ff @(posedge clk) begin
    if (acc_we_c) begin
      for (int i = 0; i < int'(LANES); i++) begin
        acc_mem[tile_cnt_q][i] <= ((ch_cnt_q == '0) ? acc_t'(0) : acc_mem[tile_cnt_q][i])
                                  + ACC_W'(psum_vec[i]);
      end
    end
  end

  // Entry 0 is presented first; afterwards read ahead one entry for 1 vector/cycle drain.
  assign rd_idx_c = out_valid ? rd_cnt_q + IDX_W'(1) : '0;

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    assign rd_acc[g] = acc_mem[rd_idx_c][g];
    psum_sat_relu #(.RELU_EN(RELU_EN)) u_sat (
      .acc      (rd_acc[g]),
      .result_c (sat_vec[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ch_m1_q    <= '0;
      ch_cnt_q   <= '0;
      tiles_m1_q <= '0;
      tile_cnt_q <= '0;
      rd_cnt_q   <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_data   <= '0;
    end else begin
      state_q    <= state_d;
      ch_m1_q    <= ch_m1_d;
      ch_cnt_q   <= ch_cnt_d;
      tiles_m1_q <= tiles_m1_d;
      tile_cnt_q <= tile_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
      busy       <= busy_d;
      done       <= done_d;
      out_data   <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_m1_d     = ch_m1_q;
    ch_cnt_d    = ch_cnt_q;
    tiles_m1_d  = tiles_m1_q;
    tile_cnt_d  = tile_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    done_d      = 1'b0;
    acc_we_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ch_m1_d = (cfg_channels == '0) ? '0 : cfg_channels - CH_W'(1);
          if (cfg_tiles == '0) begin
            tiles_m1_d = '0;
          end else if (cfg_tiles > TILES_LIM) begin
            tiles_m1_d = IDX_W'(DEPTH - 1);
          end else begin
            tiles_m1_d = IDX_W'(cfg_tiles - TILE_CFG_W'(1));
          end
          ch_cnt_d   = '0;
          tile_cnt_d = '0;
          state_d    = ACCUM;
        end
      end

      ACCUM: begin
        if (in_valid && in_ready) begin
          acc_we_c = 1'b1;
          if (tile_cnt_q == tiles_m1_q) begin
            tile_cnt_d = '0;
            ch_cnt_d   = ch_cnt_q + CH_W'(1);
            if (ch_cnt_q == ch_m1_q) begin
              rd_cnt_d = '0;
              state_d  = DRAIN;
            end
          end else begin
            tile_cnt_d = tile_cnt_q + IDX_W'(1);
          end
        end
      end

      DRAIN: begin
        if (!out_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = sat_vec;
        end else if (out_ready) begin
          if (rd_cnt_q < tiles_m1_q) begin
            rd_cnt_d   = rd_cnt_q + IDX_W'(1);
            out_data_d = sat_vec;
          end else begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == ACCUM);
    busy_d     = (state_d != IDLE);
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator; a RELU_EN=0 instance runs alongside on the same inputs.
module tb_psum_accumulator;
  import pe_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n, start, in_valid, out_ready;
  logic [9:0]   cfg_channels;
  logic [5:0]   cfg_tiles;
  logic [111:0] psum_in;
  logic         in_ready, out_valid, busy, done;
  logic [111:0] out_data;
  logic         in_ready0, out_valid0, busy0, done0;
  logic [111:0] out_data0;

  psum_accumulator #(.DEPTH(32), .RELU_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_channels(cfg_channels),
    .cfg_tiles(cfg_tiles), .in_valid(in_valid), .in_ready(in_ready), .psum_in(psum_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done));

  psum_accumulator #(.DEPTH(32), .RELU_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_channels(cfg_channels),
    .cfg_tiles(cfg_tiles), .in_valid(in_valid), .in_ready(in_ready0), .psum_in(psum_in),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .busy(busy0), .done(done0));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [111:0] stim_q[$];
  logic [111:0] exp_q[$], exp0_q[$];
  logic [111:0] got_q[$], got0_q[$];
  int           got_cyc[$];
  logic         last_done, last_busy;

  function automatic logic [15:0] sat_m(input longint x, input bit relu);
    logic [63:0] xb;
    xb = x;
    if (relu && x < 0) return 16'h0000;
    if (x > 32767) return 16'h7FFF;
    if (x < -32768) return 16'h8000;
    return xb[15:0];
  endfunction

  function automatic logic [111:0] splat(input logic [15:0] v);
    logic [111:0] r;
    for (int l = 0; l < 7; l++) r[16*l +: 16] = v;
    return r;
  endfunction

  // Model: stim_q holds channel-major vectors; push one expected vector per tile.
  task automatic push_expected(input int ch, input int tl);
    longint       acc [32][7];
    logic [111:0] e, e0, s;
    logic signed [15:0] v;
    for (int t = 0; t < 32; t++) for (int l = 0; l < 7; l++) acc[t][l] = 0;
    for (int c = 0; c < ch; c++)
      for (int t = 0; t < tl; t++) begin
        s = stim_q[c*tl + t];
        for (int l = 0; l < 7; l++) begin
          v = s[16*l +: 16];
          acc[t][l] += longint'(v);
        end
      end
    for (int t = 0; t < tl; t++) begin
      for (int l = 0; l < 7; l++) begin
        e[16*l +: 16]  = sat_m(acc[t][l], 1'b1);
        e0[16*l +: 16] = sat_m(acc[t][l], 1'b0);
      end
      exp_q.push_back(e);
      exp0_q.push_back(e0);
    end
  endtask

  task automatic apply_start(input int ch, input int tl);
    start = 1'b1; cfg_channels = 10'(ch); cfg_tiles = 6'(tl);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_vec(input logic [111:0] v, output bit ok);
    int w = 0;
    in_valid = 1'b1; psum_in = v;
    while (in_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
    ok = (in_ready === 1'b1);
    if (ok) begin @(posedge clk); #1; end
    in_valid = 1'b0;
  endtask

  task automatic send_all(output int n_sent);
    bit ok;
    n_sent = 0;
    foreach (stim_q[k]) begin
      send_vec(stim_q[k], ok);
      if (!ok) break;
      n_sent++;
    end
  endtask

  task automatic collect(input int n);
    int w;
    out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (out_valid !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
      if (out_valid !== 1'b1) break;
      got_q.push_back(out_data); got0_q.push_back(out_data0); got_cyc.push_back(cyc);
      @(posedge clk); #1;
    end
    last_done = done; last_busy = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_channels = '0; cfg_tiles = '0; psum_in = '0;
    #1;
    n_checks++; if ({in_ready, out_valid, busy, done} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {in_ready, out_valid, busy, done}); else n_pass++;
    n_checks++; if (out_data !== 112'h0) $display("FAIL reset_data: got %h want 0", out_data); else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1;
    in_valid = 1'b1; psum_in = splat(16'h1234);
    repeat (3) @(posedge clk); #1;
    n_checks++; if ({in_ready, busy, out_valid} !== 3'b000) $display("FAIL idle_ignore: got %b want 000", {in_ready, busy, out_valid}); else n_pass++;
    in_valid = 1'b0;
  endtask

  task automatic test_single();
    int n;
    stim_q = {splat(16'h0100)};
    push_expected(1, 1);
    apply_start(1, 1);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL start_to_ready: got %b want 1", in_ready); else n_pass++;
    send_all(n);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL latency_early: got %b want 0", out_valid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL latency_first: got %b want 1", out_valid); else n_pass++;
    collect(1);
    n_checks++; if (got_q.size() !== 1) $display("FAIL single_count: got %0d want 1", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      n_checks++; if (got_q[0] !== exp_q[0]) $display("FAIL single_data: got %h want %h", got_q[0], exp_q[0]); else n_pass++;
      void'(got_q.pop_front()); void'(exp_q.pop_front()); void'(got0_q.pop_front()); void'(exp0_q.pop_front());
    end
    n_checks++; if ({last_done, last_busy} !== 2'b10) $display("FAIL done_busy: got %b want 10", {last_done, last_busy}); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) $display("FAIL done_pulse: got %b want 0", done); else n_pass++;
    exp_q.delete(); exp0_q.delete(); got_q.delete(); got0_q.delete(); got_cyc.delete();
  endtask

  task automatic test_multi_channel();
    int n;
    stim_q = {splat(16'h0100), splat(16'hFF00), splat(16'h0200), splat(16'hFF00),
              splat(16'h0300), splat(16'hFF00)};
    push_expected(3, 2);
    apply_start(3, 2);
    send_all(n);
    collect(2);
    n_checks++; if (got_q.size() !== 2) $display("FAIL multi_count: got %0d want 2", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      n_checks++; if (got_q[0] !== exp_q[0]) $display("FAIL multi_data: got %h want %h", got_q[0], exp_q[0]); else n_pass++;
      n_checks++; if (got0_q[0] !== exp0_q[0]) $display("FAIL multi_norelu: got %h want %h", got0_q[0], exp0_q[0]); else n_pass++;
      void'(got_q.pop_front()); void'(exp_q.pop_front()); void'(got0_q.pop_front()); void'(exp0_q.pop_front());
    end
    exp_q.delete(); exp0_q.delete(); got_q.delete(); got0_q.delete(); got_cyc.delete();
  endtask

  task automatic test_saturation();
    int n;
    logic [111:0] v;
    v = '0; v[15:0] = 16'h7000; v[31:16] = 16'h9000; v[47:32] = 16'h0010;
    stim_q = {v, v, v, v};
    push_expected(4, 1);
    apply_start(4, 1);
    send_all(n);
    collect(1);
    n_checks++; if (got_q.size() !== 1) $display("FAIL sat_count: got %0d want 1", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      n_checks++; if (got_q[0] !== exp_q[0]) $display("FAIL sat_relu: got %h want %h", got_q[0], exp_q[0]); else n_pass++;
      n_checks++; if (got0_q[0] !== exp0_q[0]) $display("FAIL sat_norelu: got %h want %h", got0_q[0], exp0_q[0]); else n_pass++;
      void'(got_q.pop_front()); void'(exp_q.pop_front()); void'(got0_q.pop_front()); void'(exp0_q.pop_front());
    end
    exp_q.delete(); exp0_q.delete(); got_q.delete(); got0_q.delete(); got_cyc.delete();
  endtask

  task automatic test_random();
    int n;
    stim_q = {};
    for (int k = 0; k < 20; k++)
      stim_q.push_back({$urandom(), $urandom(), $urandom(), 16'($urandom())});
    push_expected(5, 4);
    apply_start(5, 4);
    send_all(n);
    n_checks++; if (n !== 20) $display("FAIL rand_sent: got %0d want 20", n); else n_pass++;
    collect(4);
    n_checks++; if (got_q.size() !== 4) $display("FAIL rand_count: got %0d want 4", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      n_checks++; if (got_q[0] !== exp_q[0]) $display("FAIL rand_data: got %h want %h", got_q[0], exp_q[0]); else n_pass++;
      n_checks++; if (got0_q[0] !== exp0_q[0]) $display("FAIL rand_norelu: got %h want %h", got0_q[0], exp0_q[0]); else n_pass++;
      void'(got_q.pop_front()); void'(exp_q.pop_front()); void'(got0_q.pop_front()); void'(exp0_q.pop_front());
    end
    exp_q.delete(); exp0_q.delete(); got_q.delete(); got0_q.delete(); got_cyc.delete();
  endtask

  task automatic test_back_to_back();
    int n;
    logic [111:0] held;
    bit ok;
    stim_q = {splat(16'h0123), splat(16'h0456)};
    push_expected(1, 2);
    out_ready = 1'b0;
    apply_start(1, 2);
    send_all(n);
    @(posedge clk); #1;
    held = out_data;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      ok = (out_valid === 1'b1) && (out_data === held) && (in_ready === 1'b0);
      n_checks++; if (!ok) $display("FAIL stall_hold: got v=%b d=%h r=%b want v=1 d=%h r=0", out_valid, out_data, in_ready, held); else n_pass++;
    end
    collect(2);
    n_checks++; if (got_q.size() !== 2) $display("FAIL b2b_count: got %0d want 2", got_q.size()); else n_pass++;
    if (got_cyc.size() == 2) begin
      n_checks++; if (got_cyc[1] - got_cyc[0] !== 1) $display("FAIL b2b_gap: got %0d want 1", got_cyc[1] - got_cyc[0]); else n_pass++;
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      n_checks++; if (got_q[0] !== exp_q[0]) $display("FAIL b2b_data: got %h want %h", got_q[0], exp_q[0]); else n_pass++;
      void'(got_q.pop_front()); void'(exp_q.pop_front()); void'(got0_q.pop_front()); void'(exp0_q.pop_front());
    end
    n_checks++; if (last_done !== 1'b1) $display("FAIL b2b_done: got %b want 1", last_done); else n_pass++;
    exp_q.delete(); exp0_q.delete(); got_q.delete(); got0_q.delete(); got_cyc.delete();
  endtask

  task automatic test_mid_reset();
    int n;
    stim_q = {splat(16'h2000), splat(16'h3000), splat(16'h1111)};
    apply_start(2, 2);
    send_all(n);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, in_ready, out_valid} !== 3'b000) $display("FAIL async_reset: got %b want 000", {busy, in_ready, out_valid}); else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1;
    stim_q = {splat(16'h0010)};
    push_expected(1, 1);
    apply_start(1, 1);
    send_all(n);
    collect(1);
    n_checks++; if (got_q.size() !== 1) $display("FAIL stale_count: got %0d want 1", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      n_checks++; if (got_q[0] !== exp_q[0]) $display("FAIL stale_data: got %h want %h", got_q[0], exp_q[0]); else n_pass++;
      void'(got_q.pop_front()); void'(exp_q.pop_front()); void'(got0_q.pop_front()); void'(exp0_q.pop_front());
    end
    exp_q.delete(); exp0_q.delete(); got_q.delete(); got0_q.delete(); got_cyc.delete();
  endtask

  task automatic test_start_ignored_zero_cfg();
    int n;
    bit ok;
    stim_q = {splat(16'h0040), splat(16'h0005)};
    push_expected(2, 1);
    apply_start(2, 1);
    send_vec(stim_q[0], ok);
    start = 1'b1; cfg_channels = '0; cfg_tiles = '0;
    @(posedge clk); #1; start = 1'b0;
    n_checks++; if ({busy, in_ready} !== 2'b11) $display("FAIL start_ignored: got %b want 11", {busy, in_ready}); else n_pass++;
    send_vec(stim_q[1], ok);
    collect(1);
    stim_q = {splat(16'h0777)};
    push_expected(1, 1);
    apply_start(0, 0);
    send_all(n);
    collect(1);
    n_checks++; if (got_q.size() !== 2) $display("FAIL zero_cfg_count: got %0d want 2", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      n_checks++; if (got_q[0] !== exp_q[0]) $display("FAIL zero_cfg_data: got %h want %h", got_q[0], exp_q[0]); else n_pass++;
      void'(got_q.pop_front()); void'(exp_q.pop_front()); void'(got0_q.pop_front()); void'(exp0_q.pop_front());
    end
    n_checks++; if ({last_done, last_busy} !== 2'b10) $display("FAIL zero_cfg_done: got %b want 10", {last_done, last_busy}); else n_pass++;
    exp_q.delete(); exp0_q.delete(); got_q.delete(); got0_q.delete(); got_cyc.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_channel();
    test_saturation();
    test_random();
    test_back_to_back();
    test_mid_reset();
    test_start_ignored_zero_cfg();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
